// File: rtl/issue_unit.sv
// issue_unit: front-end sequencer that owns the program counter. It fetches
// 16-bit instruction words and hands one registered instruction per cycle to
// decode. It also assembles two-word LDMs, applies branch redirects, holds
// on stalls, and injects hardware interrupts as CALLs.
module issue_unit #(
  parameter logic [15:0] RESET_ADDR = 16'h0000,
  parameter logic [15:0] INT_ADDR   = 16'h0001
) (
  input  logic        i_clk,
  input  logic        i_reset,
  output logic [15:0] o_pc,
  input  logic [15:0] i_instr,
  input  logic        i_stall,
  input  logic        i_branch_taken,
  input  logic [15:0] i_branch_target,
  input  logic        i_interrupt_req,
  output logic        o_valid,
  output logic [4:0]  o_opcode,
  output logic [15:0] o_instr,
  output logic [15:0] o_imm,
  output logic        o_interrupt,
  output logic [15:0] o_ret_pc
);

  localparam logic [4:0]  OP_CALL   = 5'b00101;
  localparam logic [4:0]  OP_LDM_A  = 5'b10010;
  localparam logic [4:0]  OP_LDM_B  = 5'b10001;
  localparam logic [15:0] CALL_WORD = 16'h2800;

  typedef enum logic [1:0] {
    S_VECTOR,
    S_RUN,
    S_IMM,
    S_INT_VEC
  } state_e;

  // Everything decode sees; an all-zero value is the NOP bubble.
  typedef struct packed {
    logic        valid;
    logic [4:0]  opcode;
    logic [15:0] instr;
    logic [15:0] imm;
    logic        intr;
    logic [15:0] ret_pc;
  } issue_t;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] held_q, held_d;
  logic        pending_q, pending_d;
  logic        guard_q, guard_d;   // a real instruction issued since the last injection
  issue_t      issue_q, issue_d;

  logic [15:0] pc_inc;
  logic        pending_any;
  logic        fetch_is_ldm;

  assign pc_inc       = pc_q + 16'd1;
  // A request arriving this cycle can be serviced on this very edge.
  assign pending_any  = pending_q | i_interrupt_req;
  assign fetch_is_ldm = (i_instr[15:11] == OP_LDM_A) || (i_instr[15:11] == OP_LDM_B);

  // Fetch address: fixed vectors while loading them, otherwise the PC.
  always_comb begin
    case (state_q)
      S_VECTOR:  o_pc = RESET_ADDR;
      S_INT_VEC: o_pc = INT_ADDR;
      default:   o_pc = pc_q;
    endcase
  end

  // Next-state logic: redirect beats stall, stall freezes everything but pending.
  always_comb begin
    // NOTE: every _d signal is given a hold value first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    pc_d      = pc_q;
    held_d    = held_q;
    guard_d   = guard_q;
    issue_d   = issue_q;
    pending_d = pending_any;

    if (i_branch_taken && (state_q != S_VECTOR)) begin
      pc_d    = i_branch_target;
      state_d = S_RUN;
      issue_d = '0;
      if (state_q == S_INT_VEC) begin
        // The injected CALL is killed: take the interrupt again at the target.
        pending_d = 1'b1;
        guard_d   = 1'b1;
      end
    end else if (!i_stall) begin
      case (state_q)
        S_VECTOR: begin
          pc_d    = i_instr;
          issue_d = '0;
          state_d = S_RUN;
        end
        S_RUN: begin
          if (pending_any && guard_q) begin
            issue_d.valid  = 1'b1;
            issue_d.opcode = OP_CALL;
            issue_d.instr  = CALL_WORD;
            issue_d.imm    = '0;
            issue_d.intr   = 1'b1;
            issue_d.ret_pc = pc_q;
            pending_d      = 1'b0;
            guard_d        = 1'b0;
            state_d        = S_INT_VEC;
          end else if (fetch_is_ldm) begin
            held_d  = i_instr;
            issue_d = '0;
            pc_d    = pc_inc;
            state_d = S_IMM;
          end else begin
            issue_d.valid  = 1'b1;
            issue_d.opcode = i_instr[15:11];
            issue_d.instr  = i_instr;
            issue_d.imm    = '0;
            issue_d.intr   = 1'b0;
            issue_d.ret_pc = pc_inc;
            pc_d           = pc_inc;
            guard_d        = 1'b1;
          end
        end
        S_IMM: begin
          issue_d.valid  = 1'b1;
          issue_d.opcode = held_q[15:11];
          issue_d.instr  = held_q;
          issue_d.imm    = i_instr;
          issue_d.intr   = 1'b0;
          issue_d.ret_pc = pc_inc;
          pc_d           = pc_inc;
          guard_d        = 1'b1;
          state_d        = S_RUN;
        end
        S_INT_VEC: begin
          pc_d    = i_instr;
          issue_d = '0;
          state_d = S_RUN;
        end
      endcase
    end
  end

  // State and issue registers with asynchronous reset.
  always_ff @(posedge i_clk or posedge i_reset) begin
    // NOTE: non-blocking assignments so every register samples the
    // pre-edge values regardless of statement order.
    if (i_reset) begin
      state_q   <= S_VECTOR;
      pc_q      <= '0;
      held_q    <= '0;
      pending_q <= 1'b0;
      guard_q   <= 1'b1;
      issue_q   <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      held_q    <= held_d;
      pending_q <= pending_d;
      guard_q   <= guard_d;
      issue_q   <= issue_d;
    end
  end

  assign o_valid     = issue_q.valid;
  assign o_opcode    = issue_q.opcode;
  assign o_instr     = issue_q.instr;
  assign o_imm       = issue_q.imm;
  assign o_interrupt = issue_q.intr;
  assign o_ret_pc    = issue_q.ret_pc;

endmodule

// File: tb/tb_issue_unit.sv
// tb_issue_unit: directed scenarios with literal expectations, then random
// stimulus; a behavioural model is compared with the DUT on every negedge.
module tb_issue_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] o_pc;
  logic [15:0] instr;
  logic        stall = 1'b0;
  logic        br = 1'b0;
  logic [15:0] tgt = 16'h0000;
  logic        irq = 1'b0;
  logic        o_valid;
  logic [4:0]  o_opcode;
  logic [15:0] o_instr;
  logic [15:0] o_imm;
  logic        o_interrupt;
  logic [15:0] o_ret_pc;

  logic [15:0] mem [0:65535];

  int n_cmp = 0;
  int n_bad = 0;

  issue_unit dut (
    .i_clk           (clk),
    .i_reset         (rst),
    .o_pc            (o_pc),
    .i_instr         (instr),
    .i_stall         (stall),
    .i_branch_taken  (br),
    .i_branch_target (tgt),
    .i_interrupt_req (irq),
    .o_valid         (o_valid),
    .o_opcode        (o_opcode),
    .o_instr         (o_instr),
    .o_imm           (o_imm),
    .o_interrupt     (o_interrupt),
    .o_ret_pc        (o_ret_pc)
  );

  // Instruction memory answers in the same cycle.
  assign instr = mem[o_pc];

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [15:0] m_pc, m_held;
  logic        m_boot, m_vec, m_have_held, m_pending, m_served;
  logic        e_valid, e_int;
  logic [4:0]  e_op;
  logic [15:0] e_instr, e_imm, e_ret;

  function automatic logic [15:0] exp_pc();
    if (m_boot) return 16'h0000;
    if (m_vec)  return 16'h0001;
    return m_pc;
  endfunction

  task automatic set_out(input logic v, input logic [4:0] op, input logic [15:0] ins,
                         input logic [15:0] imm, input logic intr, input logic [15:0] ret);
    e_valid = v; e_op = op; e_instr = ins; e_imm = imm; e_int = intr; e_ret = ret;
  endtask

  task automatic model_reset();
    m_pc = 16'h0000; m_held = 16'h0000;
    m_boot = 1'b1; m_vec = 1'b0; m_have_held = 1'b0;
    m_pending = 1'b0; m_served = 1'b1;
    set_out(1'b0, 5'd0, 16'h0, 16'h0, 1'b0, 16'h0);
  endtask

  task automatic model_step();
    logic [15:0] word;
    logic        pend;
    word = mem[exp_pc()];
    pend = m_pending | irq;
    if (br && !m_boot) begin
      if (m_vec) begin
        pend = 1'b1;
        m_served = 1'b1;
      end
      m_pc = tgt; m_vec = 1'b0; m_have_held = 1'b0;
      set_out(1'b0, 5'd0, 16'h0, 16'h0, 1'b0, 16'h0);
    end else if (!stall) begin
      if (m_boot) begin
        m_pc = word; m_boot = 1'b0;
        set_out(1'b0, 5'd0, 16'h0, 16'h0, 1'b0, 16'h0);
      end else if (m_vec) begin
        m_pc = word; m_vec = 1'b0;
        set_out(1'b0, 5'd0, 16'h0, 16'h0, 1'b0, 16'h0);
      end else if (m_have_held) begin
        set_out(1'b1, m_held[15:11], m_held, word, 1'b0, m_pc + 16'd1);
        m_pc = m_pc + 16'd1; m_have_held = 1'b0; m_served = 1'b1;
      end else if (pend && m_served) begin
        set_out(1'b1, 5'b00101, 16'h2800, 16'h0, 1'b1, m_pc);
        m_vec = 1'b1; pend = 1'b0; m_served = 1'b0;
      end else if (word[15:11] == 5'b10010 || word[15:11] == 5'b10001) begin
        m_held = word; m_have_held = 1'b1; m_pc = m_pc + 16'd1;
        set_out(1'b0, 5'd0, 16'h0, 16'h0, 1'b0, 16'h0);
      end else begin
        set_out(1'b1, word[15:11], word, 16'h0, 1'b0, m_pc + 16'd1);
        m_pc = m_pc + 16'd1; m_served = 1'b1;
      end
    end
    m_pending = pend;
  endtask

  // Compare process: outputs are stable at the falling edge.
  always @(negedge clk) begin
    if (rst) model_reset();
    check("model.pc",      o_pc,        exp_pc());
    check("model.valid",   o_valid,     e_valid);
    check("model.opcode",  o_opcode,    e_op);
    check("model.instr",   o_instr,     e_instr);
    check("model.imm",     o_imm,       e_imm);
    check("model.int",     o_interrupt, e_int);
    check("model.ret_pc",  o_ret_pc,    e_ret);
    if (!rst) model_step();
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input logic st, input logic b, input logic [15:0] t, input logic ir);
    stall = st; br = b; tgt = t; irq = ir;
    @(posedge clk); #1;
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [4:0] op,
                            input logic [15:0] ins, input logic [15:0] imm,
                            input logic intr, input logic [15:0] ret, input logic [15:0] pc);
    check({tag, ".valid"},  o_valid,     v);
    check({tag, ".opcode"}, o_opcode,    op);
    check({tag, ".instr"},  o_instr,     ins);
    check({tag, ".imm"},    o_imm,       imm);
    check({tag, ".int"},    o_interrupt, intr);
    check({tag, ".ret_pc"}, o_ret_pc,    ret);
    check({tag, ".pc"},     o_pc,        pc);
  endtask

  task automatic enter_reset();
    step(1'b0, 1'b0, 16'h0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic leave_reset();
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 16'h5000;
    mem[0] = 16'h0010;
    mem[1] = 16'h0100;
    @(posedge clk); #1;
    @(posedge clk); #1;

    // A: reset vector, first issue
    expect_out("rst", 1'b0, 5'h00, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0000);
    leave_reset();
    check("A.c0.pc", o_pc, 16'h0000);
    step(1'b0, 1'b0, 16'h0, 1'b0);
    expect_out("A.c1", 1'b0, 5'h00, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0010);
    step(1'b0, 1'b0, 16'h0, 1'b0);
    expect_out("A.c2", 1'b1, 5'h0A, 16'h5000, 16'h0, 1'b0, 16'h0011, 16'h0011);

    // B: LDM assembly
    enter_reset();
    mem[16] = 16'h9000; mem[17] = 16'hBEEF; mem[18] = 16'h1800;
    leave_reset();
    step(1'b0, 1'b0, 16'h0, 1'b0);
    step(1'b0, 1'b0, 16'h0, 1'b0);
    expect_out("B.bubble", 1'b0, 5'h00, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0011);
    step(1'b0, 1'b0, 16'h0, 1'b0);
    expect_out("B.ldm", 1'b1, 5'h12, 16'h9000, 16'hBEEF, 1'b0, 16'h0012, 16'h0012);
    step(1'b0, 1'b0, 16'h0, 1'b0);
    expect_out("B.not", 1'b1, 5'h03, 16'h1800, 16'h0, 1'b0, 16'h0013, 16'h0013);

    // C: interrupt injection and nesting guard
    enter_reset();
    for (int a = 16; a < 24; a++) mem[a] = 16'h5000;
    leave_reset();
    for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 16'h0, 1'b0);
    check("C.pc20", o_pc, 16'h0014);
    step(1'b0, 1'b0, 16'h0, 1'b1);
    expect_out("C.call", 1'b1, 5'h05, 16'h2800, 16'h0, 1'b1, 16'h0014, 16'h0001);
    step(1'b0, 1'b0, 16'h0, 1'b1);
    expect_out("C.vec", 1'b0, 5'h00, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0100);
    step(1'b0, 1'b0, 16'h0, 1'b0);
    expect_out("C.isr", 1'b1, 5'h0A, 16'h5000, 16'h0, 1'b0, 16'h0101, 16'h0101);
    step(1'b0, 1'b0, 16'h0, 1'b0);
    expect_out("C.call2", 1'b1, 5'h05, 16'h2800, 16'h0, 1'b1, 16'h0101, 16'h0001);

    // D: flush during IMM and during INT_VEC
    enter_reset();
    mem[16] = 16'h9000; mem[17] = 16'hBEEF;
    leave_reset();
    step(1'b0, 1'b0, 16'h0, 1'b0);
    step(1'b0, 1'b0, 16'h0, 1'b0);
    step(1'b0, 1'b1, 16'h0040, 1'b0);
    expect_out("D.flush", 1'b0, 5'h00, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0040);
    step(1'b0, 1'b0, 16'h0, 1'b0);
    expect_out("D.tgt", 1'b1, 5'h0A, 16'h5000, 16'h0, 1'b0, 16'h0041, 16'h0041);
    step(1'b0, 1'b0, 16'h0, 1'b1);
    expect_out("D.call", 1'b1, 5'h05, 16'h2800, 16'h0, 1'b1, 16'h0041, 16'h0001);
    step(1'b0, 1'b1, 16'h0040, 1'b0);
    expect_out("D.kill", 1'b0, 5'h00, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0040);
    step(1'b0, 1'b0, 16'h0, 1'b0);
    expect_out("D.recall", 1'b1, 5'h05, 16'h2800, 16'h0, 1'b1, 16'h0040, 16'h0001);

    // E: stall with interrupt, then stall plus branch
    step(1'b0, 1'b0, 16'h0, 1'b0);
    step(1'b0, 1'b0, 16'h0, 1'b0);
    expect_out("E.isr", 1'b1, 5'h0A, 16'h5000, 16'h0, 1'b0, 16'h0101, 16'h0101);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b0, 16'h0, (k == 1));
      expect_out("E.stall", 1'b1, 5'h0A, 16'h5000, 16'h0, 1'b0, 16'h0101, 16'h0101);
    end
    step(1'b0, 1'b0, 16'h0, 1'b0);
    expect_out("E.call", 1'b1, 5'h05, 16'h2800, 16'h0, 1'b1, 16'h0101, 16'h0001);
    step(1'b0, 1'b0, 16'h0, 1'b0);
    step(1'b0, 1'b0, 16'h0, 1'b0);
    step(1'b1, 1'b1, 16'h0200, 1'b0);
    expect_out("E.stallbr", 1'b0, 5'h00, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0200);

    // F: PC wrap, then asynchronous reset in IMM
    step(1'b0, 1'b1, 16'hFFFF, 1'b0);
    check("F.ffff", o_pc, 16'hFFFF);
    step(1'b0, 1'b0, 16'h0, 1'b0);
    expect_out("F.wrap", 1'b1, 5'h0A, 16'h5000, 16'h0, 1'b0, 16'h0000, 16'h0000);
    mem[16'h0030] = 16'h9000;
    step(1'b0, 1'b1, 16'h0030, 1'b0);
    step(1'b0, 1'b0, 16'h0, 1'b0);
    check("F.imm.pc", o_pc, 16'h0031);
    #2 rst = 1'b1;
    #1 expect_out("F.async", 1'b0, 5'h00, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0000);
    @(posedge clk); #1;
    leave_reset();
    step(1'b0, 1'b0, 16'h0, 1'b0);
    check("F.revector", o_pc, 16'h0010);

    // Random phase
    enter_reset();
    for (int a = 0; a < 65536; a++) mem[a] = 16'($urandom);
    leave_reset();
    for (int k = 0; k < 3000; k++) begin
      step(($urandom_range(0, 99) < 20), ($urandom_range(0, 99) < 8),
           16'($urandom), ($urandom_range(0, 99) < 6));
      if ($urandom_range(0, 499) == 0) begin
        #2 rst = 1'b1;
        @(posedge clk); #1;
        leave_reset();
      end
    end
    step(1'b0, 1'b0, 16'h0, 1'b0);
    @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/issue_unit.md
# issue_unit

Front-end sequencer that owns the program counter. It fetches 16-bit instruction words and presents one decoded-ready instruction per cycle to the decode stage's control unit: a 5-bit opcode, the full word and the immediate. It handles:
- reset-vector load;
- two-word LDM assembly;
- branch redirect and flush;
- stall;
- hardware interrupt injection as a CALL opcode with the interrupt flag set.

## Interface
- RESET_ADDR, 16'h0000, instruction-memory address holding the reset vector
- INT_ADDR, 16'h0001, instruction-memory address holding the interrupt vector
- i_clk  in  1  clock, rising edge
- i_reset  in  1  asynchronous, active-high reset
- o_pc  out  16  instruction-memory address (combinational from state/PC)
- i_instr  in  16  instruction-memory read data for o_pc, valid same cycle
- i_stall  in  1  hazard stall; hold all state
- i_branch_taken  in  1  redirect request (JZ/JN/JC/JMP/CALL/RET/RTI resolved downstream)
- i_branch_target  in  16  redirect address
- i_interrupt_req  in  1  external interrupt; a single-cycle pulse suffices
- o_valid  out  1  issue register holds a real instruction
- o_opcode  out  5  issued opcode, word[15:11]; 5'b00000 (NOP) when not valid
- o_instr  out  16  issued word (register and shamt fields); 0 when not valid
- o_imm  out  16  immediate for LDM; 0 otherwise
- o_interrupt  out  1  issued CALL is an interrupt entry; drives decode i_interrupt
- o_ret_pc  out  16  return address for CALL or interrupt push

## Operation
- States:
  - VECTOR: fetch the reset vector.
  - RUN: normal issue.
  - IMM: second word of LDM.
  - INT_VEC: fetch the interrupt vector.
- o_pc by state: VECTOR drives RESET_ADDR; INT_VEC drives INT_ADDR; RUN and IMM drive the PC register.
- VECTOR:
  - PC<=i_instr; issue NOP; go to RUN.
- RUN, opcode 5'b10010 or 5'b10001 (two-word LDM):
  - Hold the word internally; issue NOP; PC<=PC+1; go to IMM.
- RUN, any other opcode:
  - Issue the word: o_valid=1, o_opcode=word[15:11].
  - o_ret_pc<=PC+1; PC<=PC+1.
- IMM:
  - Issue the held word with o_imm<=i_instr and o_ret_pc<=PC+1.
  - PC<=PC+1; go to RUN.
- Interrupt pending flag:
  - Set by i_interrupt_req in any state, including during a stall.
  - Cleared on injection.
- Injection:
  - Occurs in RUN only, when pending is set, no stall and no redirect, and at least one real instruction has issued since the last injection (nesting guard).
  - Issues o_opcode=5'b00101 with o_valid=1, o_interrupt=1, o_instr=16'h2800 and o_ret_pc=PC.
  - PC is not incremented; the word at PC is not issued.
  - Goes to INT_VEC.
- INT_VEC:
  - PC<=i_instr; issue NOP; go to RUN.
- Redirect (i_branch_taken):
  - Redirect is highest priority after reset and beats stall.
  - PC<=i_branch_target; issue register<=NOP; go to RUN.
  - Redirect abandons IMM: the held LDM is discarded.
  - Redirect in INT_VEC kills the injected CALL: re-arm pending, clear the nesting guard, drop the vector fetch.
  - Redirect in VECTOR is ignored.
- Stall:
  - PC, state, issue register and held word are unchanged.
  - Only the pending flag may change.
- PC arithmetic: 16-bit modulo; 16'hFFFF+1 = 16'h0000.

## Timing
- Reset values of all outputs:
  - o_valid=0, o_opcode=0, o_instr=0, o_imm=0, o_interrupt=0, o_ret_pc=0.
  - o_pc=RESET_ADDR.
- Reset internal state: state=VECTOR, PC=0, pending=0, nesting guard satisfied.
- Reset asserted mid-operation returns to these values immediately, without waiting for a clock edge.
- Issue outputs are registered: the word fetched in cycle N appears on the outputs in cycle N+1.
- After reset release:
  - Cycle 0: vector fetch.
  - Cycle 1: fetch at the vector target.
  - Cycle 2: first valid issue.
- LDM occupies two fetch cycles and produces one valid issue with one bubble.
- Interrupt latency from pending:
  - The CALL issues on the next eligible RUN edge.
  - The vector fetch follows one cycle later.
  - The first ISR fetch is two cycles after the CALL.
- A redirect takes effect on the edge where it is sampled; the instruction fetched that cycle is never issued.

## Test plan
- Reset: mem[0]=16'h0010, mem[16]=ADD (16'h5000), release reset → o_pc 0,16,17; ADD valid in cycle 2 with o_ret_pc=17.
- LDM: mem[16]=16'h9000, mem[17]=16'hBEEF, mem[18]=NOT → one NOP bubble; LDM issued with o_imm=16'hBEEF and o_ret_pc=18; then NOT issues with PC=19.
- Interrupt: pulse at PC=20, INT vector mem[1]=16'h0100 → CALL issues with o_interrupt=1 and o_ret_pc=20; o_pc becomes 1, then 16'h0100; a second pulse during INT_VEC is serviced only after the first ISR instruction issues.
- Flush: i_branch_taken with target 16'h0040 during IMM → held LDM dropped, issue register NOP, next issue from 16'h0040; repeat during INT_VEC → pending re-armed, CALL re-injected with o_ret_pc=16'h0040.
- Stall with simultaneous events: i_stall high 3 cycles while an interrupt pulses → outputs and o_pc frozen, CALL issues on the first unstalled edge; stall plus branch in the same cycle → redirect wins.
- Wrap and async reset: PC=16'hFFFF issues then fetches 16'h0000; assert i_reset between clock edges mid-IMM → outputs zero immediately and state returns to VECTOR.
